uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
- Parametrised successor to the fixed 8N1 serial receiver used on the AVS control link.
- Configurable data width, parity mode and stop-bit count; stop and parity bits are checked.
- Output is a valid/ready handshake with an overrun flag.
- Sits between the board RX pin and the command/sample deserialiser.

Parameters:
- CLKS_PER_BIT, 125, i_Clock cycles per bit (clock freq / baud); must be >= 4.
- DATA_BITS, 8, data bits per frame, range 5..9, LSB first.
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, 1 or 2.
- CNT_W, 16, clock-counter width; must hold CLKS_PER_BIT-1.

Ports:
- i_Clock  in  1  sole clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Rx_Serial  in  1  asynchronous serial line, idle high.
- o_Rx_Valid  out  1  frame available; held until accepted.
- i_Rx_Ready  in  1  consumer accepts when o_Rx_Valid && i_Rx_Ready.
- o_Rx_Data  out  DATA_BITS  received data, stable while o_Rx_Valid.
- o_Parity_Err  out  1  parity mismatch for the presented frame; qualified by o_Rx_Valid.
- o_Frame_Err  out  1  any stop bit sampled 0; qualified by o_Rx_Valid.
- o_Overrun  out  1  one-cycle pulse when a completed frame is dropped.
- o_Busy  out  1  high when the FSM is not in IDLE.

Behaviour:
- Single clock, i_Clock. Reset is synchronous and active-high on i_Reset.
- Input synchroniser: two flops, both reset to 1. All FSM decisions use the second flop (rx_s).
- Reset values:
  - All outputs 0 (o_Rx_Data = 0); FSM in IDLE; counters 0.
  - Reset mid-frame abandons the frame; no valid, no error output.
- IDLE: counter = 0, bit index = 0. Go to START when rx_s == 0.
- START:
  - Count to (CLKS_PER_BIT-1)/2.
  - At that count: rx_s == 0 → counter = 0, go to DATA; otherwise return to IDLE (glitch rejected, nothing reported).
- DATA:
  - When the counter reaches CLKS_PER_BIT-1, sample rx_s into shift bit [index] and reset the counter.
  - After bit DATA_BITS-1: go to PARITY if PARITY_MODE != 0, else STOP.
- PARITY:
  - Sample once at CLKS_PER_BIT-1.
  - Error condition: even mode → (XOR of data ^ sampled bit) != 0; odd mode → that value == 0.
- STOP:
  - Sample each of the STOP_BITS bits at CLKS_PER_BIT-1.
  - Any 0 sets the frame-error flag.
  - After the last stop sample, go to DONE.
  - The stop bit is sampled mid-bit, so the receiver re-arms half a bit early and back-to-back frames are received.
- DONE (1 cycle), then IDLE:
  - If o_Rx_Valid == 0, or it is being accepted this cycle: load o_Rx_Data and both error flags, and set o_Rx_Valid.
  - Otherwise: drop the new frame, pulse o_Overrun; held data and flags are unchanged.
- Handshake:
  - o_Rx_Valid clears on the cycle after an acceptance, unless DONE reloads it in that same cycle; the reload wins and o_Rx_Valid stays 1.
  - o_Rx_Data and the flags must not change while o_Rx_Valid == 1 and not accepted.
- Latency: o_Rx_Valid rises 1 cycle after the final stop-bit sample (DONE registered). The line-to-sample delay includes the 2 synchroniser cycles.
- Widths:
  - The counter compares against CNT_W-bit constants.
  - The bit index is $clog2(DATA_BITS) bits wide and never exceeds DATA_BITS-1.
- Illegal FSM encoding → IDLE.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each data, parity and stop sample is the majority of rx_s at counts CLKS_PER_BIT-2, CLKS_PER_BIT-1 and the next cycle.
  - The next-bit counter restarts at 0 on the vote cycle, so bit timing is unchanged.
  - The start check uses the majority around (CLKS_PER_BIT-1)/2.
- Not defined: single sample, as above. Timing of o_Rx_Valid is identical in both builds.

Decomposition:
- Package uart_pkg:
  - FSM state typedef: IDLE, START, DATA, PARITY, STOP, DONE.
  - PARITY_NONE/EVEN/ODD constants.
  - Shared with the planned uart_tx_param.
- Sub-module uart_bit_sampler:
  - Contains the synchroniser, bit-centre counter and (optional) majority vote.
  - Outputs a sample strobe plus the sampled value.
  - Used by the FSM top.

Test Plan (CLKS_PER_BIT=8 unless stated):
- 8N1, send 0xA5, i_Rx_Ready tied 1:
  - o_Rx_Valid high one cycle, o_Rx_Data=0xA5, no errors.
  - Repeat back-to-back 0x00 then 0xFF: both received.
- Start glitch: line low 2 cycles then high → o_Busy pulses, FSM returns to IDLE, o_Rx_Valid never asserts.
- DATA_BITS=7, PARITY_MODE=1:
  - Send 0x3C with parity 0 → data 0x3C, o_Parity_Err=0.
  - Same data with parity 1 → o_Parity_Err=1.
- STOP_BITS=2, second stop bit driven 0 → o_Frame_Err=1, data intact.
- i_Rx_Ready=0, send 0x11 then 0x22:
  - o_Rx_Data holds 0x11, o_Overrun pulses once.
  - Assert ready → valid drops the next cycle.
- i_Reset asserted during bit 3 of 0x55:
  - All outputs 0, FSM back in IDLE.
  - Next frame 0x66 received correctly.
  - Rerun with UART_RX_MAJORITY_EN and a 1-cycle inverted glitch at the centre of each data bit → 0x66 still received.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and parity helpers shared by the parametrised UART receiver and transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } uart_state_t;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_EVEN = 2'd1;
  localparam logic [1:0] PARITY_ODD  = 2'd2;

  // Error flag from the XOR of all data bits and the received parity bit.
  function automatic logic parity_error(input logic xor_all, input logic [1:0] mode);
    case (mode)
      PARITY_EVEN: return xor_all;
      PARITY_ODD:  return ~xor_all;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_param_sampler.sv
// uart_bit_sampler: RX synchroniser, bit-centre counter and sample strobe.
// With UART_RX_MAJORITY_EN defined the sample is a 3-tap majority vote around the strobe point.
module uart_bit_sampler #(
  parameter int unsigned CLKS_PER_BIT = 125,
  parameter int unsigned CNT_W        = 16
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Rx_Serial,
  input  logic i_Run,
  input  logic i_Half,
  output logic o_Rx_Sync,
  output logic o_Strobe_c,
  output logic o_Sample_c
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             w_at_end;

  // Two-flop synchroniser, idle-high after reset.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_Rx_Serial;
      r_sync2 <= r_sync1;
    end
  end

  assign w_at_end = (r_cnt == (i_Half ? HALF_CNT : LAST_CNT));

  // Counter runs only while the FSM is inside a frame and restarts at every strobe.
  always_ff @(posedge i_Clock) begin
    if (i_Reset || !i_Run || w_at_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_Strobe_c = i_Run && w_at_end;
  assign o_Rx_Sync  = r_sync2;

`ifdef UART_RX_MAJORITY_EN
  logic r_prev;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= r_sync2;
    end
  end

  // r_sync1 is the value rx_s takes on the following cycle, so the vote needs no extra latency.
  assign o_Sample_c = (r_prev & r_sync2) | (r_prev & r_sync1) | (r_sync2 & r_sync1);
`else
  assign o_Sample_c = r_sync2;
`endif

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised serial receiver (5..9 data bits, none/even/odd parity, 1-2 stop bits)
// with a valid/ready output and overrun pulse. UART_RX_MAJORITY_EN selects majority-vote sampling.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 125,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_Valid,
  input  logic                 i_Rx_Ready,
  output logic [DATA_BITS-1:0] o_Rx_Data,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Overrun,
  output logic                 o_Busy
);

  localparam int unsigned          IDX_W    = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [1:0]           MODE     = 2'(PARITY_MODE);
  localparam logic                 LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_t          r_state;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_stop_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_err;
  logic                 r_frame_err;

  logic w_rx_s;
  logic w_strobe;
  logic w_sample;
  logic w_run;
  logic w_half;
  logic w_accept;

  assign w_run    = (r_state == START) || (r_state == DATA) ||
                    (r_state == PARITY) || (r_state == STOP);
  assign w_half   = (r_state == START);
  assign w_accept = o_Rx_Valid && i_Rx_Ready;

  uart_bit_sampler #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_sampler (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .i_Rx_Serial (i_Rx_Serial),
    .i_Run       (w_run),
    .i_Half      (w_half),
    .o_Rx_Sync   (w_rx_s),
    .o_Strobe_c  (w_strobe),
    .o_Sample_c  (w_sample)
  );

  // Frame FSM plus output holding register; DONE reload takes priority over an acceptance clear.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_stop_idx   <= 1'b0;
      r_shift      <= '0;
      r_par_err    <= 1'b0;
      r_frame_err  <= 1'b0;
      o_Rx_Valid   <= 1'b0;
      o_Rx_Data    <= '0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Overrun    <= 1'b0;
      o_Busy       <= 1'b0;
    end else begin
      o_Overrun <= 1'b0;
      if (w_accept) begin
        o_Rx_Valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          r_idx       <= '0;
          r_stop_idx  <= 1'b0;
          r_par_err   <= 1'b0;
          r_frame_err <= 1'b0;
          if (!w_rx_s) begin
            r_state <= START;
            o_Busy  <= 1'b1;
          end
        end

        START: begin
          if (w_strobe) begin
            if (!w_sample) begin
              r_state <= DATA;
            end else begin
              r_state <= IDLE;
              o_Busy  <= 1'b0;
            end
          end
        end

        DATA: begin
          if (w_strobe) begin
            r_shift[r_idx] <= w_sample;
            if (r_idx == LAST_IDX) begin
              r_idx   <= '0;
              r_state <= (MODE != PARITY_NONE) ? PARITY : STOP;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end

        PARITY: begin
          if (w_strobe) begin
            r_par_err <= parity_error((^r_shift) ^ w_sample, MODE);
            r_state   <= STOP;
          end
        end

        STOP: begin
          if (w_strobe) begin
            if (!w_sample) begin
              r_frame_err <= 1'b1;
            end
            if (r_stop_idx == LAST_STOP) begin
              r_state <= DONE;
            end else begin
              r_stop_idx <= 1'b1;
            end
          end
        end

        DONE: begin
          r_state <= IDLE;
          o_Busy  <= 1'b0;
          if (!o_Rx_Valid || w_accept) begin
            o_Rx_Valid   <= 1'b1;
            o_Rx_Data    <= r_shift;
            o_Parity_Err <= r_par_err;
            o_Frame_Err  <= r_frame_err;
          end else begin
            o_Overrun <= 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
          o_Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: scoreboard bench driving three receiver configurations (8N1, 7E1, 8N2).
module tb_uart_rx_param;

  localparam int unsigned CPB = 8;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] r_line = 3'b111;
  logic [2:0] r_ready = 3'b111;

  logic       v0, pe0, fe0, ov0, b0;
  logic [7:0] d0;
  logic       v1, pe1, fe1, ov1, b1;
  logic [6:0] d1;
  logic       v2, pe2, fe2, ov2, b2;
  logic [7:0] d2;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int n_cmp = 0;
  int n_bad = 0;
  int ovr_cnt = 0;
  int busy_seen = 0;

  always #5 clk = ~clk;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .CNT_W(16)) u_dut_8n1 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(r_line[0]), .o_Rx_Valid(v0), .i_Rx_Ready(r_ready[0]),
    .o_Rx_Data(d0), .o_Parity_Err(pe0), .o_Frame_Err(fe0), .o_Overrun(ov0), .o_Busy(b0));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(1), .CNT_W(16)) u_dut_7e1 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(r_line[1]), .o_Rx_Valid(v1), .i_Rx_Ready(r_ready[1]),
    .o_Rx_Data(d1), .o_Parity_Err(pe1), .o_Frame_Err(fe1), .o_Overrun(ov1), .o_Busy(b1));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2), .CNT_W(16)) u_dut_8n2 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(r_line[2]), .o_Rx_Valid(v2), .i_Rx_Ready(r_ready[2]),
    .o_Rx_Data(d2), .o_Parity_Err(pe2), .o_Frame_Err(fe2), .o_Overrun(ov2), .o_Busy(b2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int q_size(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push(input int d, input logic [8:0] data, input logic perr, input logic ferr);
    exp_t e;
    e.data = data;
    e.perr = perr;
    e.ferr = ferr;
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic sb_compare(input int d, input logic [8:0] data, input logic perr, input logic ferr);
    exp_t e;
    bit   have;
    have = 1'b0;
    e    = '0;
    case (d)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      check($sformatf("dut%0d_unexpected_valid", d), 32'd1, 32'd0);
    end else begin
      check($sformatf("dut%0d_data", d), 32'(data), 32'(e.data));
      check($sformatf("dut%0d_parity_err", d), 32'(perr), 32'(e.perr));
      check($sformatf("dut%0d_frame_err", d), 32'(ferr), 32'(e.ferr));
    end
  endtask

  // Output monitors: pop and compare on every accepted frame.
  always @(negedge clk) if (!rst && v0 && r_ready[0]) sb_compare(0, {1'b0, d0}, pe0, fe0);
  always @(negedge clk) if (!rst && v1 && r_ready[1]) sb_compare(1, {2'b0, d1}, pe1, fe1);
  always @(negedge clk) if (!rst && v2 && r_ready[2]) sb_compare(2, {1'b0, d2}, pe2, fe2);

  always @(negedge clk) begin
    if (ov0) ovr_cnt++;
    if (b0)  busy_seen++;
  end

  task automatic drive_bit(input int d, input logic b, input bit glitch, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      r_line[d] = (glitch && c == 4) ? ~b : b;
    end
  endtask

  task automatic send_frame(input int d, input logic [8:0] data, input int nbits, input bit par_en,
                            input logic pbit, input int nstop, input logic stop2, input bit glitch);
    drive_bit(d, 1'b0, 1'b0, CPB);
    for (int i = 0; i < nbits; i++) drive_bit(d, data[i], glitch, CPB);
    if (par_en) drive_bit(d, pbit, 1'b0, CPB);
    drive_bit(d, 1'b1, 1'b0, CPB);
    if (nstop == 2) begin
      drive_bit(d, stop2, 1'b0, CPB);
      if (!stop2) drive_bit(d, 1'b1, 1'b0, CPB);
    end
  endtask

  task automatic wait_drain(input int d);
    for (int i = 0; i < 300; i++) begin
      if (q_size(d) == 0) return;
      @(negedge clk);
    end
    check($sformatf("dut%0d_drain_timeout", d), 32'(q_size(d)), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 32'(v0), 32'd0);
    check({tag, "_data"}, 32'(d0), 32'd0);
    check({tag, "_perr"}, 32'(pe0), 32'd0);
    check({tag, "_ferr"}, 32'(fe0), 32'd0);
    check({tag, "_overrun"}, 32'(ov0), 32'd0);
    check({tag, "_busy"}, 32'(b0), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] d7;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // 8N1 back-to-back frames with ready tied high
    push(0, 9'h0A5, 1'b0, 1'b0);
    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    push(0, 9'h000, 1'b0, 1'b0);
    send_frame(0, 9'h000, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    push(0, 9'h0FF, 1'b0, 1'b0);
    send_frame(0, 9'h0FF, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    wait_drain(0);
    repeat (10) @(negedge clk);

    // Start glitch: busy must pulse, no frame reported
    busy_seen = 0;
    drive_bit(0, 1'b0, 1'b0, 2);
    drive_bit(0, 1'b1, 1'b0, 3 * CPB);
    check("glitch_busy_seen", 32'(busy_seen > 0), 32'd1);
    check("glitch_busy_end", 32'(b0), 32'd0);
    check("glitch_valid", 32'(v0), 32'd0);

    // 7E1: correct and wrong parity
    d7 = 7'h3C;
    push(1, 9'h03C, (^d7) ^ 1'b0, 1'b0);
    send_frame(1, 9'h03C, 7, 1'b1, 1'b0, 1, 1'b1, 1'b0);
    push(1, 9'h03C, (^d7) ^ 1'b1, 1'b0);
    send_frame(1, 9'h03C, 7, 1'b1, 1'b1, 1, 1'b1, 1'b0);
    d7 = 7'h07;
    push(1, 9'h007, (^d7) ^ 1'b1, 1'b0);
    send_frame(1, 9'h007, 7, 1'b1, 1'b1, 1, 1'b1, 1'b0);
    wait_drain(1);

    // 8N2: bad second stop bit, then a clean frame
    push(2, 9'h05A, 1'b0, 1'b1);
    send_frame(2, 9'h05A, 8, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    push(2, 9'h0C3, 1'b0, 1'b0);
    send_frame(2, 9'h0C3, 8, 1'b0, 1'b0, 2, 1'b1, 1'b0);
    wait_drain(2);

    // Overrun: consumer stalled, second frame dropped
    @(negedge clk);
    r_ready[0] = 1'b0;
    ovr_cnt = 0;
    push(0, 9'h011, 1'b0, 1'b0);
    send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    send_frame(0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    repeat (12) @(negedge clk);
    check("ovr_valid_held", 32'(v0), 32'd1);
    check("ovr_data_held", 32'(d0), 32'h11);
    check("ovr_pulse_count", 32'(ovr_cnt), 32'd1);
    @(posedge clk);
    #1 r_ready[0] = 1'b1;
    @(negedge clk);
    check("ovr_valid_at_accept", 32'(v0), 32'd1);
    @(negedge clk);
    check("ovr_valid_drop", 32'(v0), 32'd0);
    check("ovr_queue_empty", 32'(q_size(0)), 32'd0);

    // Reset during data bit 3 of 0x55
    repeat (5) @(negedge clk);
    drive_bit(0, 1'b0, 1'b0, CPB);
    for (int i = 0; i < 3; i++) drive_bit(0, (i % 2 == 0), 1'b0, CPB);
    drive_bit(0, 1'b0, 1'b0, 4);
    check("abort_busy_before", 32'(b0), 32'd1);
    @(negedge clk);
    r_line[0] = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("abort");
    repeat (3 * CPB) @(negedge clk);
    check("abort_no_valid", 32'(v0), 32'd0);
    push(0, 9'h066, 1'b0, 1'b0);
    send_frame(0, 9'h066, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    wait_drain(0);

`ifdef UART_RX_MAJORITY_EN
    // One-cycle inverted glitch at the centre of every data bit
    repeat (5) @(negedge clk);
    push(0, 9'h066, 1'b0, 1'b0);
    send_frame(0, 9'h066, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    wait_drain(0);
`endif

    repeat (20) @(negedge clk);
    check("final_q0_empty", 32'(q_size(0)), 32'd0);
    check("final_q1_empty", 32'(q_size(1)), 32'd0);
    check("final_q2_empty", 32'(q_size(2)), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
